// File: rtl/mux_pkg.sv
// Shared constants and width helper for the streaming N:1 mux family.
package mux_pkg;

  localparam int MUX_MAX_N    = 16;
  localparam int MUX_NO_GRANT = 0;

  function automatic int mux_sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_nx1.sv
// Combinational round-robin pick: first requester at or after ptr, modulo N.
module rr_arbiter_nx1
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = mux_sel_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_id,
  output logic          gnt_any
);

  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    gnt_id  = SW'(MUX_NO_GRANT);
    gnt_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt_id  = SW'((int'(ptr) + i) % N);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// N:1 valid/ready mux with registered output stage.
// MUX_NX1_RR_ARB_EN selects round-robin arbitration instead of explicit sel.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = mux_sel_w(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] grant_id
);

  logic          load;
  logic          ch_ok;
  logic          xfer;
  logic [SW-1:0] ch;
  logic [W-1:0]  ch_data;

  assign load = !out_valid || out_ready;

`ifdef MUX_NX1_RR_ARB_EN
  logic [SW-1:0] rr_ptr;
  logic          unused_sel;

  assign unused_sel = ^sel;

  rr_arbiter_nx1 #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_id  (ch),
    .gnt_any (ch_ok)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (int'(ch) == N - 1) ? '0 : ch + SW'(1);
    end
  end
`else
  assign ch = sel;

  // Out-of-range selects only exist when N is not a power of two.
  if ((1 << SW) == N) begin : g_pow2
    assign ch_ok = 1'b1;
  end else begin : g_npow2
    assign ch_ok = (sel < SW'(N));
  end
`endif

  always_comb begin
    in_ready = '0;
    ch_data  = '0;
    for (int c = 0; c < N; c++) begin
      in_ready[c] = load && ch_ok && (int'(ch) == c);
      if (int'(ch) == c) ch_data = in_data[c*W +: W];
    end
  end

  assign xfer = |(in_ready & in_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_id  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data;
      grant_id  <= ch;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule
